// File: rtl/note_ctrl_if.sv
// note_ctrl_if -- MIDI byte stream handshake.
//   midi_byte  : received MIDI byte (source -> voice)
//   midi_valid : midi_byte valid this cycle (source -> voice)
//   midi_ready : voice can take a byte (voice -> source); a byte moves on
//                a rising edge where midi_valid && midi_ready
interface note_ctrl_if;
  logic [7:0] midi_byte;
  logic       midi_valid;
  logic       midi_ready;

  modport master (output midi_byte, output midi_valid, input  midi_ready);
  modport slave  (input  midi_byte, input  midi_valid, output midi_ready);
endinterface

// File: rtl/note_ctrl.sv
// note_ctrl -- monophonic MIDI voice controller (last-note priority).
// Parses note-on/note-off for one MIDI channel (running status supported),
// converts the note number into an NCO phase increment by repeated
// subtraction of 12 (octave count) followed by a table lookup and shift.
//   clk, rst_n  : clock, async active-low reset
//   midi        : byte stream handshake (slave side)
//   step_size   : NCO phase increment
//   note_vel    : velocity of the current note
//   note_active : a note is sounding
//   cur_note    : current / last note number
module note_ctrl #(
  parameter int CHANNEL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  note_ctrl_if.slave  midi,
  output logic [15:0] step_size,
  output logic [6:0]  note_vel,
  output logic        note_active,
  output logic [6:0]  cur_note
);
  localparam logic [3:0] CH = 4'(CHANNEL);

  // Top-octave phase increments: round(8372.018*2^(k/12)*65536/96000)
  localparam logic [15:0] STEP_TOP [0:11] = '{
    16'd5715, 16'd6055, 16'd6415, 16'd6797, 16'd7201, 16'd7629,
    16'd8083, 16'd8563, 16'd9072, 16'd9612, 16'd10184, 16'd10789
  };

  typedef enum logic [2:0] {IDLE, D1, D2, DIV, LOAD} state_t;

  state_t     state;
  logic       ready_q;
  logic       rs_valid;   // running status refers to our note-on/off
  logic       rs_on;      // running status is note-on (0x9n)
  logic [6:0] note_q;
  logic [6:0] vel_q;
  logic [6:0] rem;
  logic [3:0] oct;

  logic       acc;
  logic [7:0] b;

  assign midi.midi_ready = ready_q;
  assign acc = midi.midi_valid && ready_q;
  assign b   = midi.midi_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      rs_valid    <= 1'b0;
      rs_on       <= 1'b0;
      note_q      <= '0;
      vel_q       <= '0;
      rem         <= '0;
      oct         <= '0;
      step_size   <= '0;
      note_vel    <= '0;
      note_active <= 1'b0;
      cur_note    <= '0;
    end else begin
      case (state)
        IDLE, D1, D2: begin
          if (acc) begin
            if (b[7]) begin
              if (b >= 8'hF8) begin
                // real-time: transparent to the parser
              end else if (b >= 8'hF0) begin
                rs_valid <= 1'b0;
                state    <= IDLE;
              end else begin
                rs_on <= b[4];
                if ((b[7:4] == 4'h9 || b[7:4] == 4'h8) && b[3:0] == CH) begin
                  rs_valid <= 1'b1;
                  state    <= D1;
                end else begin
                  rs_valid <= 1'b0;
                  state    <= IDLE;
                end
              end
            end else if (state == D2) begin
              if (rs_on && b[6:0] != 7'd0) begin
                vel_q   <= b[6:0];
                rem     <= note_q;
                oct     <= '0;
                ready_q <= 1'b0;
                state   <= DIV;
              end else begin
                // note-off (or note-on with zero velocity)
                if (note_q == cur_note) note_active <= 1'b0;
                state <= D1;
              end
            end else if (state == D1 || rs_valid) begin
              note_q <= b[6:0];
              state  <= D2;
            end
          end
        end
        DIV: begin
          if (rem >= 7'd12) begin
            rem <= rem - 7'd12;
            oct <= oct + 4'd1;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          step_size   <= STEP_TOP[rem[3:0]] >> (4'd10 - oct);
          note_vel    <= vel_q;
          cur_note    <= note_q;
          note_active <= 1'b1;
          ready_q     <= 1'b1;
          state       <= D1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_note_ctrl.sv
// tb_note_ctrl -- self-checking bench for note_ctrl (CHANNEL=0):
// directed byte table, hand sequences for reset-in-conversion and a held
// byte, then random bytes against a message-level reference model.
module tb_note_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_ctrl_if mif();
  logic [15:0] step_size;
  logic [6:0]  note_vel;
  logic        note_active;
  logic [6:0]  cur_note;

  note_ctrl #(.CHANNEL(0)) dut (
    .clk(clk), .rst_n(rst_n), .midi(mif),
    .step_size(step_size), .note_vel(note_vel),
    .note_active(note_active), .cur_note(cur_note)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int s, input int v, input int a, input int c);
    chk({tag, ".step"}, 32'(step_size), s);
    chk({tag, ".vel"},  32'(note_vel), v);
    chk({tag, ".act"},  32'(note_active), a);
    chk({tag, ".cur"},  32'(cur_note), c);
  endtask

  // Send one byte; optionally wait for the voice to become ready again,
  // reporting how many edges that took and whether outputs moved early.
  task automatic xfer(input int b, input bit wait_busy, output int lat, output bit early);
    int w;
    logic [30:0] snap;
    lat = 0;
    early = 1'b0;
    w = 0;
    while (!mif.midi_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout got 0 expected 1");
    end
    snap = {step_size, note_vel, note_active, cur_note};
    mif.midi_byte  = 8'(b);
    mif.midi_valid = 1'b1;
    @(posedge clk); #1;
    mif.midi_valid = 1'b0;
    if (wait_busy) begin
      while (!mif.midi_ready && lat < 20) begin
        if ({step_size, note_vel, note_active, cur_note} !== snap) early = 1'b1;
        @(posedge clk); #1; lat++;
      end
    end
  endtask

  task automatic reset_dut();
    mif.midi_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- reference model (message level) ----------------
  int step_top [12];
  int m_rsv, m_rson, m_ph, m_note;
  int e_step, e_vel, e_act, e_cur;

  task automatic model_reset();
    m_rsv = 0; m_rson = 0; m_ph = 0; m_note = 0;
    e_step = 0; e_vel = 0; e_act = 0; e_cur = 0;
  endtask

  // m_ph: 0 = waiting for status, 1 = want note, 2 = want velocity
  task automatic model_byte(input int b, output int lat);
    lat = 0;
    if (b >= 'hF8) begin
    end else if (b >= 'hF0) begin
      m_rsv = 0; m_ph = 0;
    end else if (b >= 'h80) begin
      m_rson = ((b >> 4) == 9);
      if (((b >> 4) == 8 || (b >> 4) == 9) && (b % 16) == 0) begin
        m_rsv = 1; m_ph = 1;
      end else begin
        m_rsv = 0; m_ph = 0;
      end
    end else if (m_ph == 2) begin
      if (m_rson != 0 && b != 0) begin
        lat    = m_note / 12 + 2;
        e_step = step_top[m_note % 12] >> (10 - m_note / 12);
        e_vel  = b;
        e_cur  = m_note;
        e_act  = 1;
      end else if (m_note == e_cur) begin
        e_act = 0;
      end
      m_ph = 1;
    end else if (m_ph == 1 || m_rsv != 0) begin
      m_note = b; m_ph = 2;
    end
  endtask

  typedef struct {
    int b; int lat; int step; int vel; int act; int cur;
  } vec_t;
  vec_t tv[$];

  task automatic add(input int b, input int lat, input int s, input int v, input int a, input int c);
    vec_t e;
    e.b = b; e.lat = lat; e.step = s; e.vel = v; e.act = a; e.cur = c;
    tv.push_back(e);
  endtask

  initial begin
    int lat, n, b, r, mlat;
    bit early, acc;
    string tag;

    for (int k = 0; k < 12; k++)
      step_top[k] = $rtoi(8372.018 * (2.0 ** (k / 12.0)) * 65536.0 / 96000.0 + 0.5);

    mif.midi_valid = 1'b0;
    mif.midi_byte  = 8'h00;
    reset_dut();
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.ready", 32'(mif.midi_ready), 1);

    // byte, latency, step, vel, active, cur_note (after the byte settles)
    add('h90, 0, 0, 0, 0, 0);        add('h45, 0, 0, 0, 0, 0);
    add('h64, 7, 300, 100, 1, 69);
    add('h7F, 0, 300, 100, 1, 69);   add('h40, 12, 8563, 64, 1, 127);
    add('h45, 0, 8563, 64, 1, 127);  add('h64, 7, 300, 100, 1, 69);
    add('h80, 0, 300, 100, 1, 69);   add('h3C, 0, 300, 100, 1, 69);
    add('h00, 0, 300, 100, 1, 69);
    add('h90, 0, 300, 100, 1, 69);   add('h45, 0, 300, 100, 1, 69);
    add('h00, 0, 300, 100, 0, 69);
    add('h91, 0, 300, 100, 0, 69);   add('h45, 0, 300, 100, 0, 69);
    add('h64, 0, 300, 100, 0, 69);
    add('h90, 0, 300, 100, 0, 69);   add('hF8, 0, 300, 100, 0, 69);
    add('h3C, 0, 300, 100, 0, 69);   add('hF8, 0, 300, 100, 0, 69);
    add('h20, 7, 178, 32, 1, 60);
    add('h45, 0, 178, 32, 1, 60);    add('h00, 0, 178, 32, 1, 60);
    add('hF0, 0, 178, 32, 1, 60);    add('h3C, 0, 178, 32, 1, 60);
    add('h00, 0, 178, 32, 1, 60);
    add('h90, 0, 178, 32, 1, 60);    add('h00, 0, 178, 32, 1, 60);
    add('h01, 2, 5, 1, 1, 0);
    add('h90, 0, 5, 1, 1, 0);        add('h30, 0, 5, 1, 1, 0);
    add('h90, 0, 5, 1, 1, 0);        add('h0C, 0, 5, 1, 1, 0);
    add('h7F, 3, 11, 127, 1, 12);
    add('h93, 0, 11, 127, 1, 12);    add('h0C, 0, 11, 127, 1, 12);
    add('h7F, 0, 11, 127, 1, 12);

    for (int i = 0; i < tv.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      xfer(tv[i].b, 1'b1, lat, early);
      chk({tag, ".lat"}, lat, tv[i].lat);
      chk({tag, ".early"}, 32'(early), 0);
      chk_out(tag, tv[i].step, tv[i].vel, tv[i].act, tv[i].cur);
    end

    // Reset in the middle of converting note 127: nothing may be loaded.
    xfer('h90, 1'b1, lat, early);
    xfer('h7F, 1'b1, lat, early);
    xfer('h40, 1'b0, lat, early);
    chk("div.busy", 32'(mif.midi_ready), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst_async", 0, 0, 0, 0);
    chk("rst_async.ready", 32'(mif.midi_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk_out("rst_abort", 0, 0, 0, 0);
    xfer('h45, 1'b1, lat, early);
    xfer('h64, 1'b1, lat, early);
    chk("rst_idle.lat", lat, 0);
    chk_out("rst_idle", 0, 0, 0, 0);

    // Byte offered while busy must wait, then be taken exactly once.
    xfer('h90, 1'b1, lat, early);
    xfer('h3C, 1'b1, lat, early);
    xfer('h40, 1'b0, lat, early);
    mif.midi_byte  = 8'h48;
    mif.midi_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 30) begin
      acc = mif.midi_ready;
      @(posedge clk); #1;
      if (!acc) n++;
    end
    mif.midi_valid = 1'b0;
    chk("held.wait", n, 7);
    chk_out("held.note60", 178, 64, 1, 60);
    xfer('h10, 1'b1, lat, early);
    chk("held.lat", lat, 8);
    chk_out("held.note72", 357, 16, 1, 72);

    // Random bytes against the reference model.
    reset_dut();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 12) b = 'h90;
      else if (r < 18) b = 'h80;
      else if (r < 22) b = 'h90 + $urandom_range(1, 15);
      else if (r < 26) b = $urandom_range('hF8, 'hFF);
      else if (r < 28) b = $urandom_range('hF0, 'hF7);
      else if (r < 31) b = $urandom_range('hA0, 'hEF);
      else if (r < 36) b = 0;
      else             b = $urandom_range(0, 127);
      model_byte(b, mlat);
      xfer(b, 1'b1, lat, early);
      tag = $sformatf("rnd%0d_b%0h", i, b);
      chk({tag, ".lat"}, lat, mlat);
      chk({tag, ".early"}, 32'(early), 0);
      chk_out(tag, e_step, e_vel, e_act, e_cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
